// File: rtl/fpu_pkg.sv
// Shared types and constants for the parametrised FP add/subtract unit.
package fpu_pkg;

    localparam int FPU_EXP_W = 6;
    localparam int FPU_MAN_W = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_OPERATE,
        ST_NORM,
        ST_ROUND,
        ST_PACK
    } state_t;

    localparam logic [3:0] STATUS_EXACT     = 4'b0001;
    localparam logic [3:0] STATUS_INEXACT   = 4'b0010;
    localparam logic [3:0] STATUS_OVERFLOW  = 4'b0100;
    localparam logic [3:0] STATUS_UNDERFLOW = 4'b1000;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; all-zero input returns WIDTH.
module fpu_lzc #(
    parameter int WIDTH = 29,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle FP add/subtract, fixed 5-cycle latency, start/done handshake.
// Define FPU_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fpu_addsub_param
    import fpu_pkg::*;
#(
    parameter int EXP_W = FPU_EXP_W,
    parameter int MAN_W = FPU_MAN_W,
    parameter int BIAS  = 2**(EXP_W-1) - 1,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clock100KHz,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] op_A_in,
    input  logic [W-1:0] op_B_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);

    localparam int EW2 = EXP_W + 2;      // signed exponent path
    localparam int SW  = MAN_W + 5;      // carry, hidden, mantissa, G, R, S
    localparam int XW  = 2*MAN_W + 4;    // alignment shifter
    localparam int LZW = $clog2(SW);
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'(2**EXP_W - 1);
    localparam logic signed [EW2-1:0] EXP_MIN = EW2'(1);

    if (W != 1 + EXP_W + MAN_W || BIAS < 1) begin : g_bad_cfg
        $error("fpu_addsub_param: W must equal 1+EXP_W+MAN_W and BIAS must be positive");
    end

    state_t                state_q, state_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic signed [EW2-1:0] exp_q, exp_d;
    logic [SW-1:0]         sig_q, sig_d, small_q, small_d;
    logic                  sign_q, sign_d, sub_q, sub_d;
    logic                  zero_q, zero_d, inexact_q, inexact_d;
    logic [W-1:0]          data_q, data_d;
    logic [3:0]            status_q, status_d;
    logic                  done_q, done_d;

    // ALIGN helpers
    logic                  a_big;
    logic [W-2:0]          mag_big, mag_small;
    logic [EXP_W-1:0]      e_big, e_small, e_diff;
    logic [MAN_W:0]        sig_big, sig_small;
    logic [XW-1:0]         shifted;
    logic [SW-1:0]         aligned;

    assign a_big     = a_q[W-2:0] >= b_q[W-2:0];
    assign mag_big   = a_big ? a_q[W-2:0] : b_q[W-2:0];
    assign mag_small = a_big ? b_q[W-2:0] : a_q[W-2:0];
    assign e_big     = mag_big[W-2 -: EXP_W];
    assign e_small   = mag_small[W-2 -: EXP_W];
    assign sig_big   = (e_big == '0)   ? '0 : {1'b1, mag_big[MAN_W-1:0]};
    assign sig_small = (e_small == '0) ? '0 : {1'b1, mag_small[MAN_W-1:0]};
    assign e_diff    = e_big - e_small;
    assign shifted   = {sig_small, {(MAN_W+3){1'b0}}} >> e_diff;
    // Everything below R collapses into S; very large shifts leave only S.
    assign aligned   = (32'(e_diff) >= 32'(MAN_W + 3))
                     ? {{(SW-1){1'b0}}, |sig_small}
                     : {1'b0, shifted[XW-1 -: MAN_W+3], |shifted[MAN_W:0]};

    logic [SW-1:0]         sum;
    logic [LZW-1:0]        lz;
    logic signed [EW2-1:0] lz_ext;

    assign sum    = sub_q ? (sig_q - small_q) : (sig_q + small_q);
    assign lz_ext = EW2'(lz);

    fpu_lzc #(.WIDTH(SW - 1), .CNT_W(LZW)) u_lzc (
        .data_i  (sig_q[SW-2:0]),
        .count_o (lz)
    );

`ifdef FPU_RNE_EN
    localparam int RW = MAN_W + 2;
    logic          round_up;
    logic [RW-1:0] rounded;

    assign round_up = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
    assign rounded  = {1'b0, sig_q[SW-2:3]} + RW'(round_up);
`endif

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            status_q <= STATUS_EXACT;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clock100KHz) begin
        a_q       <= a_d;
        b_q       <= b_d;
        exp_q     <= exp_d;
        sig_q     <= sig_d;
        small_q   <= small_d;
        sign_q    <= sign_d;
        sub_q     <= sub_d;
        zero_q    <= zero_d;
        inexact_q <= inexact_d;
    end

    // The done cycle is spent in IDLE, so a start there launches the next
    // operation and gives back-to-back issue every 6 cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ALIGN;
            ST_ALIGN:   state_d = ST_OPERATE;
            ST_OPERATE: state_d = ST_NORM;
            ST_NORM:    state_d = ST_ROUND;
            ST_ROUND:   state_d = ST_PACK;
            ST_PACK:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        exp_d     = exp_q;
        sig_d     = sig_q;
        small_d   = small_q;
        sign_d    = sign_q;
        sub_d     = sub_q;
        zero_d    = zero_q;
        inexact_d = inexact_q;
        data_d    = data_q;
        status_d  = status_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d = op_A_in;
                    b_d = {op_B_in[W-1] ^ op, op_B_in[W-2:0]};
                end
            end
            ST_ALIGN: begin
                sig_d   = {1'b0, sig_big, 3'b000};
                small_d = aligned;
                exp_d   = EW2'(e_big);
                sign_d  = a_big ? a_q[W-1] : b_q[W-1];
                sub_d   = a_q[W-1] ^ b_q[W-1];
            end
            ST_OPERATE: begin
                sig_d  = sum;
                zero_d = (sum == '0);
            end
            ST_NORM: begin
                if (sig_q[SW-1]) begin
                    sig_d = {1'b0, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
                    exp_d = exp_q + EW2'(1);
                end else begin
                    sig_d = sig_q << lz;
                    exp_d = exp_q - lz_ext;
                end
            end
            ST_ROUND: begin
                inexact_d = |sig_q[2:0];
`ifdef FPU_RNE_EN
                if (rounded[RW-1]) begin
                    sig_d = {1'b0, rounded[RW-1:1], 3'b000};
                    exp_d = exp_q + EW2'(1);
                end else begin
                    sig_d = {1'b0, rounded[RW-2:0], 3'b000};
                end
`endif
            end
            ST_PACK: begin
                done_d = 1'b1;
                if (zero_q) begin
                    data_d   = '0;
                    status_d = STATUS_EXACT;
                end else if (exp_q > EXP_MAX) begin
                    data_d   = {sign_q, {(W-1){1'b1}}};
                    status_d = STATUS_OVERFLOW;
                end else if (exp_q < EXP_MIN) begin
                    data_d   = {sign_q, {(W-1){1'b0}}};
                    status_d = STATUS_UNDERFLOW;
                end else begin
                    data_d   = {sign_q, exp_q[EXP_W-1:0], sig_q[SW-3:3]};
                    status_d = inexact_q ? STATUS_INEXACT : STATUS_EXACT;
                end
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE) | done_q;
    assign done       = done_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Directed-vector bench for fpu_addsub_param in the default 1/6/25 format.
module tb_fpu_addsub_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic [3:0]  st;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fpu_addsub_param dut (
        .clock100KHz (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .op_A_in     (a),
        .op_B_in     (b),
        .busy        (busy),
        .done        (done),
        .data_out    (dout),
        .status_out  (st)
    );

    // Launch one operation from IDLE and wait (bounded) for done.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                          output logic [31:0] d, output logic [3:0] s, output int lat);
        a = ia; b = ib; op = iop; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        d = dout;
        s = st;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (busy !== 1'b0)   begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0)   begin nerr++; $display("FAIL reset_done got %b want 0", done); end
        nvec++; if (dout !== 32'h0)  begin nerr++; $display("FAIL reset_data got %h want 00000000", dout); end
        nvec++; if (st !== 4'b0001)  begin nerr++; $display("FAIL reset_status got %b want 0001", st); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_exact();
        logic [31:0] d; logic [3:0] s; int lat;
        run_op(32'h3E000000, 32'h3E000000, 1'b0, d, s, lat);
        nvec++; if (lat !== 5)            begin nerr++; $display("FAIL add_latency got %0d want 5", lat); end
        nvec++; if (d !== 32'h40000000)   begin nerr++; $display("FAIL add_data got %h want 40000000", d); end
        nvec++; if (s !== 4'b0001)        begin nerr++; $display("FAIL add_status got %b want 0001", s); end
    endtask

    task automatic test_cancel();
        logic [31:0] d; logic [3:0] s; int lat;
        run_op(32'h3E000000, 32'h3E000000, 1'b1, d, s, lat);
        nvec++; if (lat !== 5)            begin nerr++; $display("FAIL cancel_latency got %0d want 5", lat); end
        nvec++; if (d !== 32'h00000000)   begin nerr++; $display("FAIL cancel_data got %h want 00000000", d); end
        nvec++; if (s !== 4'b0001)        begin nerr++; $display("FAIL cancel_status got %b want 0001", s); end
    endtask

    task automatic test_rounding();
        logic [31:0] d; logic [3:0] s; int lat;
        logic [31:0] want_up;
`ifdef FPU_RNE_EN
        want_up = 32'h3E000001;
`else
        want_up = 32'h3E000000;
`endif
        run_op(32'h3E000000, 32'h0A000000, 1'b0, d, s, lat);
        nvec++; if (d !== 32'h3E000000)   begin nerr++; $display("FAIL tie_data got %h want 3E000000", d); end
        nvec++; if (s !== 4'b0010)        begin nerr++; $display("FAIL tie_status got %b want 0010", s); end
        run_op(32'h3E000000, 32'h0B000000, 1'b0, d, s, lat);
        nvec++; if (d !== want_up)        begin nerr++; $display("FAIL above_half_data got %h want %h", d, want_up); end
        nvec++; if (s !== 4'b0010)        begin nerr++; $display("FAIL above_half_status got %b want 0010", s); end
    endtask

    task automatic test_mixed();
        logic [31:0] d; logic [3:0] s; int lat;
        // 1.5 + 1.0 = 2.5
        run_op(32'h3F000000, 32'h3E000000, 1'b0, d, s, lat);
        nvec++; if (d !== 32'h40800000)   begin nerr++; $display("FAIL add_carry_data got %h want 40800000", d); end
        nvec++; if (s !== 4'b0001)        begin nerr++; $display("FAIL add_carry_status got %b want 0001", s); end
        // 1.0 - 1.5 = -0.5
        run_op(32'h3E000000, 32'h3F000000, 1'b1, d, s, lat);
        nvec++; if (d !== 32'hBC000000)   begin nerr++; $display("FAIL sub_neg_data got %h want BC000000", d); end
        nvec++; if (s !== 4'b0001)        begin nerr++; $display("FAIL sub_neg_status got %b want 0001", s); end
        // 0 + 1.5 = 1.5
        run_op(32'h00000000, 32'h3F000000, 1'b0, d, s, lat);
        nvec++; if (d !== 32'h3F000000)   begin nerr++; $display("FAIL zero_add_data got %h want 3F000000", d); end
        nvec++; if (s !== 4'b0001)        begin nerr++; $display("FAIL zero_add_status got %b want 0001", s); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic [3:0] s; int lat;
        run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, d, s, lat);
        nvec++; if (d !== 32'h7FFFFFFF)   begin nerr++; $display("FAIL ovf_data got %h want 7FFFFFFF", d); end
        nvec++; if (s !== 4'b0100)        begin nerr++; $display("FAIL ovf_status got %b want 0100", s); end
    endtask

    task automatic test_underflow();
        logic [31:0] d; logic [3:0] s; int lat;
        run_op(32'h02000001, 32'h02000000, 1'b1, d, s, lat);
        nvec++; if (d !== 32'h00000000)   begin nerr++; $display("FAIL unf_data got %h want 00000000", d); end
        nvec++; if (s !== 4'b1000)        begin nerr++; $display("FAIL unf_status got %b want 1000", s); end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        a = 32'h3E000000; b = 32'h3E000000; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nvec++; if (busy !== 1'b0)  begin nerr++; $display("FAIL abort_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0)  begin nerr++; $display("FAIL abort_done got %b want 0", done); end
        nvec++; if (dout !== 32'h0) begin nerr++; $display("FAIL abort_data got %h want 00000000", dout); end
        nvec++; if (st !== 4'b0001) begin nerr++; $display("FAIL abort_status got %b want 0001", st); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        nvec++; if (ndone !== 0)    begin nerr++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        int first = -1;
        a = 32'h3E000000; b = 32'h3E000000; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nvec++; if (busy !== 1'b1)  begin nerr++; $display("FAIL ignore_busy_high got %b want 1", busy); end
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
            start = (c == 1 || c == 3);
            b = 32'h3F000000; op = 1'b1;
        end
        start = 1'b0;
        nvec++; if (ndone !== 1)          begin nerr++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        nvec++; if (first !== 5)          begin nerr++; $display("FAIL ignore_done_cycle got %0d want 5", first); end
        nvec++; if (dout !== 32'h40000000) begin nerr++; $display("FAIL ignore_data got %h want 40000000", dout); end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        a = 32'h3E000000; b = 32'h3E000000; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        op = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        nvec++; if (lat !== 5)            begin nerr++; $display("FAIL b2b_first_latency got %0d want 5", lat); end
        nvec++; if (dout !== 32'h40000000) begin nerr++; $display("FAIL b2b_first_data got %h want 40000000", dout); end
        @(posedge clk); #1;
        start = 1'b0;
        nvec++; if (done !== 1'b0)        begin nerr++; $display("FAIL b2b_done_pulse got %b want 0", done); end
        nvec++; if (busy !== 1'b1)        begin nerr++; $display("FAIL b2b_second_busy got %b want 1", busy); end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        nvec++; if (lat !== 5)            begin nerr++; $display("FAIL b2b_second_latency got %0d want 5", lat); end
        nvec++; if (dout !== 32'h00000000) begin nerr++; $display("FAIL b2b_second_data got %h want 00000000", dout); end
        nvec++; if (st !== 4'b0001)       begin nerr++; $display("FAIL b2b_second_status got %b want 0001", st); end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_exact();
        test_cancel();
        test_rounding();
        test_mixed();
        test_overflow();
        test_reset_abort();
        test_underflow();
        test_busy_ignore();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
